// File: rtl/imu_bcast_mac_pkg.sv
// Shared constants, mode encodings and FSM state type for the broadcast MAC.
// Lane packing helpers live here so every file slices vectors the same way.
package imu_pkg;

    localparam int LANES_DEF = 4;
    localparam int DW_DEF    = 32;
    localparam int ACC_W_DEF = 32;
    localparam int LEN_W_DEF = 8;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GROUP = 1'b1
    } state_t;

    // Low bit index of a lane inside a packed lane vector (lane 0 in the LSBs).
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/imu_bcast_mac_if.sv
// Input beat and CBB output handshake bundle for the broadcast MAC.
// The slave modport is the MAC side; the master modport drives beats and consumes results.
interface imu_bcast_mac_if
    import imu_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
);

    logic                   in_valid;
    logic                   in_ready;
    logic [DW-1:0]          value;
    logic [LANES*DW-1:0]    row;
    logic [LANES-1:0]       lane_mask;
    logic                   mode;
    logic [LEN_W-1:0]       len;
    logic [LANES*ACC_W-1:0] data;
    logic                   CBB_valid;
    logic                   CBB_ready;

    modport slave (
        input  in_valid, value, row, lane_mask, mode, len, CBB_ready,
        output in_ready, data, CBB_valid
    );

    modport master (
        output in_valid, value, row, lane_mask, mode, len, CBB_ready,
        input  in_ready, data, CBB_valid
    );

endinterface

// File: rtl/imu_bcast_mac_lane_mul.sv
// One lane of the broadcast multiply: unsigned value*operand, truncated to ACC_W, zeroed when masked.
module imu_lane_mul
    import imu_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [DW-1:0]    value,
    input  logic [DW-1:0]    operand,
    input  logic             en,
    output logic [ACC_W-1:0] prod
);

    logic [ACC_W-1:0] a;
    logic [ACC_W-1:0] b;

    // Only the ACC_W LSBs of the product survive, so operate at that width directly.
    assign a    = ACC_W'(value);
    assign b    = ACC_W'(operand);
    assign prod = en ? (a * b) : '0;

endmodule

// File: rtl/imu_bcast_mac.sv
// Broadcast-scalar multiply/accumulate over LANES row operands with valid/ready on both sides.
// state | meaning
// IDLE  | no group open; next accepted beat is a single product or opens a group
// GROUP | accumulate group open; mode/len inputs ignored until the latched length is reached
module imu_bcast_mac
    import imu_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    imu_bcast_mac_if.slave       bus,
    output logic                 busy
);

    state_t                 state;
    state_t                 state_nxt;
    logic [LEN_W-1:0]       cnt;
    logic [LEN_W-1:0]       cnt_nxt;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       len_q_nxt;
    logic [LEN_W-1:0]       len_eff;
    logic                   p_last_nxt;

    logic                   adv;
    logic                   accept;

    logic [LANES*ACC_W-1:0] prod;
    logic [LANES*ACC_W-1:0] p;
    logic                   p_valid;
    logic                   p_last;

    logic [LANES*ACC_W-1:0] acc;
    logic [LANES*ACC_W-1:0] acc_sum;
    logic [LANES*ACC_W-1:0] data_q;
    logic                   out_valid;

    // Whole pipeline moves together whenever the output slot is free or being drained.
    assign adv          = ~out_valid | bus.CBB_ready;
    assign accept       = bus.in_valid & adv;
    assign bus.in_ready = adv;
    assign bus.data     = data_q;
    assign bus.CBB_valid = out_valid;

    assign len_eff = (bus.len == '0) ? LEN_W'(1) : bus.len;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        imu_lane_mul #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_mul (
            .value   (bus.value),
            .operand (bus.row[lane_lo(i, DW) +: DW]),
            .en      (bus.lane_mask[i]),
            .prod    (prod[lane_lo(i, ACC_W) +: ACC_W])
        );

        assign acc_sum[lane_lo(i, ACC_W) +: ACC_W] =
            acc[lane_lo(i, ACC_W) +: ACC_W] + p[lane_lo(i, ACC_W) +: ACC_W];
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        len_q_nxt  = len_q;
        p_last_nxt = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    len_q_nxt = len_eff;
                    cnt_nxt   = LEN_W'(1);
                    if ((bus.mode == MODE_ACC) && (len_eff != LEN_W'(1))) begin
                        p_last_nxt = 1'b0;
                        state_nxt  = GROUP;
                    end
                end
            end
            GROUP: begin
                p_last_nxt = 1'b0;
                if (accept) begin
                    if ((cnt + LEN_W'(1)) == len_q) begin
                        p_last_nxt = 1'b1;
                        cnt_nxt    = '0;
                        state_nxt  = IDLE;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            len_q <= len_q_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p       <= '0;
        end else if (adv) begin
            p_valid <= bus.in_valid;
            if (bus.in_valid) begin
                p      <= prod;
                p_last <= p_last_nxt;
            end
        end
    end

    // The last beat of a group goes straight to the output and leaves the accumulator clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            data_q    <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            if (p_valid && p_last) begin
                data_q    <= acc_sum;
                out_valid <= 1'b1;
                acc       <= '0;
            end else if (p_valid) begin
                acc       <= acc_sum;
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == GROUP) | p_valid | out_valid;

endmodule

// File: tb/tb_imu_bcast_mac.sv
// Scoreboard bench for imu_bcast_mac: a lane model predicts each result at accept time,
// a monitor pops and compares on every output handshake.
module tb_imu_bcast_mac;

    typedef logic [127:0] vec_t;

    logic clk;
    logic rst;
    logic busy;

    imu_bcast_mac_if #(.LANES(4), .DW(32), .ACC_W(32), .LEN_W(8)) bus ();

    imu_bcast_mac #(.LANES(4), .DW(32), .ACC_W(32), .LEN_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t exp_q[$];
    vec_t m_acc;
    bit   m_grp;
    int   m_rem;

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic vec_t lane_prods(input logic [31:0] v, input vec_t r, input logic [3:0] m);
        vec_t        res;
        logic [63:0] full;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            full = {32'd0, v} * {32'd0, r[i*32 +: 32]};
            if (m[i]) res[i*32 +: 32] = full[31:0];
        end
        return res;
    endfunction

    function automatic vec_t lane_add(input vec_t a, input vec_t b);
        vec_t res;
        for (int i = 0; i < 4; i++) res[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
        return res;
    endfunction

    task automatic model_accept(input logic [31:0] v, input vec_t r, input logic [3:0] m,
                                input logic md, input logic [7:0] ln);
        vec_t pv;
        int   leff;
        pv = lane_prods(v, r, m);
        if (!m_grp) begin
            leff = (ln == 8'd0) ? 1 : int'(ln);
            if (md == 1'b0 || leff == 1) begin
                exp_q.push_back(pv);
            end else begin
                m_grp = 1'b1;
                m_rem = leff - 1;
                m_acc = pv;
            end
        end else begin
            m_acc = lane_add(m_acc, pv);
            m_rem--;
            if (m_rem == 0) begin
                exp_q.push_back(m_acc);
                m_acc = '0;
                m_grp = 1'b0;
            end
        end
    endtask

    // Called at negedge+1; returns at negedge+1 after the accepting posedge.
    task automatic send(input logic [31:0] v, input vec_t r, input logic [3:0] m,
                        input logic md, input logic [7:0] ln);
        logic ok;
        bus.value     = v;
        bus.row       = r;
        bus.lane_mask = m;
        bus.mode      = md;
        bus.len       = ln;
        bus.in_valid  = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            #1 ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("accept", vec_t'(ok), 1);
        if (ok) model_accept(v, r, m, md, ln);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && busy; n++) tick();
        chk("drain_busy", vec_t'(busy), 0);
        chk("drain_queue", vec_t'(exp_q.size()), 0);
    endtask

    initial begin
        int got_n;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus.CBB_valid && bus.CBB_ready) begin
                got_n = exp_q.size();
                chk("out_expected", vec_t'(got_n != 0), 1);
                if (got_n != 0) chk("sb_data", bus.data, exp_q.pop_front());
            end
        end
    end

    localparam vec_t ROW0123 = {32'd3, 32'd2, 32'd1, 32'd0};
    localparam vec_t ROW1234 = {32'd4, 32'd3, 32'd2, 32'd1};

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.value     = '0;
        bus.row       = '0;
        bus.lane_mask = '0;
        bus.mode      = 1'b0;
        bus.len       = '0;
        bus.CBB_ready = 1'b1;
        m_acc = '0;
        m_grp = 1'b0;
        m_rem = 0;

        tick();
        chk("rst_valid", vec_t'(bus.CBB_valid), 0);
        chk("rst_data", bus.data, 0);
        chk("rst_busy", vec_t'(busy), 0);
        chk("rst_in_ready", vec_t'(bus.in_ready), 1);
        rst = 1'b0;
        tick();

        // per-beat multiply and latency
        send(32'd5, ROW0123, 4'hF, 1'b0, 8'd0);
        chk("lat_p_valid", vec_t'(bus.CBB_valid), 0);
        chk("lat_p_busy", vec_t'(busy), 1);
        tick();
        chk("lat_o_valid", vec_t'(bus.CBB_valid), 1);
        chk("mul_data", bus.data, {32'd15, 32'd10, 32'd5, 32'd0});
        tick();
        chk("mul_pulse", vec_t'(bus.CBB_valid), 0);

        // group of three
        send(32'd1, ROW1234, 4'hF, 1'b1, 8'd3);
        chk("grp_no_valid1", vec_t'(bus.CBB_valid), 0);
        send(32'd2, ROW1234, 4'hF, 1'b1, 8'd3);
        chk("grp_no_valid2", vec_t'(bus.CBB_valid), 0);
        send(32'd3, ROW1234, 4'hF, 1'b1, 8'd3);
        chk("grp_no_valid3", vec_t'(bus.CBB_valid), 0);
        tick();
        chk("grp_valid", vec_t'(bus.CBB_valid), 1);
        chk("grp_data", bus.data, {32'd24, 32'd18, 32'd12, 32'd6});
        tick();
        send(32'd1, ROW1234, 4'hF, 1'b0, 8'd0);
        tick();
        chk("grp_acc_clear", bus.data, ROW1234);
        wait_idle();

        // backpressure
        bus.CBB_ready = 1'b0;
        send(32'd2, ROW1234, 4'hF, 1'b0, 8'd0);
        send(32'd3, ROW1234, 4'hF, 1'b0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", vec_t'(bus.in_ready), 0);
            chk("bp_valid", vec_t'(bus.CBB_valid), 1);
            chk("bp_data", bus.data, {32'd8, 32'd6, 32'd4, 32'd2});
            tick();
        end
        bus.CBB_ready = 1'b1;
        #1;
        chk("bp_release_ready", vec_t'(bus.in_ready), 1);
        tick();
        chk("bp_next_valid", vec_t'(bus.CBB_valid), 1);
        chk("bp_next_data", bus.data, {32'd12, 32'd9, 32'd6, 32'd3});
        wait_idle();

        // wrap and mask
        send(32'hFFFF_FFFF, {32'd9, 32'd8, 32'd7, 32'd2}, 4'b0001, 1'b0, 8'd0);
        tick();
        chk("wrap_data", bus.data, {96'd0, 32'hFFFF_FFFE});
        tick();
        send(32'hFFFF_FFFF, {32'd9, 32'd8, 32'd7, 32'd2}, 4'b0001, 1'b1, 8'd2);
        send(32'hFFFF_FFFF, {32'd9, 32'd8, 32'd7, 32'd2}, 4'b0001, 1'b1, 8'd2);
        tick();
        chk("wrap_grp_data", bus.data, {96'd0, 32'hFFFF_FFFC});
        wait_idle();

        // reset mid-group
        send(32'd1, ROW1234, 4'hF, 1'b1, 8'd4);
        send(32'd2, ROW1234, 4'hF, 1'b1, 8'd4);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", vec_t'(bus.CBB_valid), 0);
        chk("mid_rst_busy", vec_t'(busy), 0);
        chk("mid_rst_data", bus.data, 0);
        m_grp = 1'b0;
        m_acc = '0;
        tick();
        rst = 1'b0;
        send(32'd5, ROW0123, 4'hF, 1'b0, 8'd0);
        tick();
        chk("post_rst_data", bus.data, {32'd15, 32'd10, 32'd5, 32'd0});
        wait_idle();

        // len=0 acts as 1, then mode/len latched for the open group
        send(32'd7, {96'd0, 32'd3}, 4'hF, 1'b1, 8'd0);
        tick();
        chk("len0_valid", vec_t'(bus.CBB_valid), 1);
        chk("len0_data", bus.data, {96'd0, 32'd21});
        tick();
        send(32'd1, {96'd0, 32'd3}, 4'hF, 1'b1, 8'd2);
        send(32'd10, {96'd0, 32'd3}, 4'hF, 1'b0, 8'd9);
        chk("latch_busy", vec_t'(busy), 1);
        tick();
        chk("latch_close", vec_t'(bus.CBB_valid), 1);
        chk("latch_data", bus.data, {96'd0, 32'd33});
        tick();
        send(32'd2, {96'd0, 32'd3}, 4'hF, 1'b0, 8'd0);
        wait_idle();

        // longest group length
        for (int i = 0; i < 255; i++) begin
            send(32'd1, {96'd0, 32'd1}, 4'hF, 1'b1, 8'd255);
            if (i == 253) chk("max_len_open", vec_t'(bus.CBB_valid), 0);
        end
        tick();
        chk("max_len_data", bus.data, {96'd0, 32'd255});
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imu_bcast_mac.md
Name: imu_bcast_mac

Overview:
- Parametrised successor to the 4-lane IMU.
- Broadcasts one scalar `value` against LANES packed row operands and multiplies per lane.
- Either emits each product vector directly (mode 0) or accumulates a group of `len` beats per lane and emits the sum (mode 1).
- Output goes to the CBB via a valid/ready handshake with backpressure; input uses valid/ready so an upstream fetch unit can stall.

Parameters:
- LANES, 4, number of parallel lanes
- DW, 32, width of `value` and of each row element
- ACC_W, 32, width of each output lane / accumulator
- LEN_W, 8, width of group-length field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready at posedge
- value  in  DW  broadcast scalar
- row  in  LANES*DW  lane operands; lane i at [i*DW +: DW]; lane 0 in the LSBs
- lane_mask  in  LANES  1 = lane active; 0 forces a zero product
- mode  in  1  0 = per-beat multiply, 1 = accumulate group
- len  in  LEN_W  beats per group (mode 1); 0 treated as 1
- data  out  LANES*ACC_W  result; lane i at [i*ACC_W +: ACC_W]
- CBB_valid  out  1  data valid
- CBB_ready  in  1  CBB consumes data when CBB_valid & CBB_ready
- busy  out  1  group open or pipeline non-empty

Behaviour:
- Reset: async on rst high. CBB_valid=0, data=0, all accumulators 0, beat counter 0, stage-P valid 0, FSM=IDLE, busy=0. A partial group in flight at reset is discarded.
- Arithmetic: product_i = value * row_i, unsigned. The product is truncated to its ACC_W LSBs and is 0 if lane_mask[i]=0. Accumulation is unsigned add modulo 2^ACC_W; no saturation and no overflow flag.
- Pipeline: stage P registers products plus a p_last flag. Stage O holds the accumulator and the output register.
  - Advance condition: adv = ~CBB_valid | CBB_ready. in_ready = adv, which is combinational from CBB_ready.
  - Latency: a beat accepted at edge n produces CBB_valid high after edge n+1 (mode 0, or the last beat of a group).
  - Stages P and O both load only when adv=1; otherwise everything holds.
- Stage O, on adv:
  - If p_valid & p_last: data <= acc + p, CBB_valid <= 1, acc <= 0.
  - If p_valid & ~p_last: acc <= acc + p, CBB_valid <= 0.
  - If ~p_valid: CBB_valid <= 0.
- Handshake rules: data and CBB_valid hold stable while CBB_valid & ~CBB_ready. A new output may load in the same cycle the previous one is consumed, giving full throughput of one beat per cycle.
- FSM (beat bookkeeping at accept):
  - IDLE: on accept, latch mode and max(len,1), set cnt=1.
    - If mode=0 or len≤1: p_last=1 and stay in IDLE.
    - Else: p_last=0 and go to GROUP.
  - GROUP: mode/len inputs are ignored. Each accept increments cnt. When cnt+1 == latched len: p_last=1, cnt=0, go to IDLE.
- Boundaries:
  - len=0 behaves as len=1.
  - len=2^LEN_W−1 is supported; cnt is LEN_W wide and never wraps mid-group.
  - in_valid low mid-group leaves the group open indefinitely.
  - A mask change mid-group applies per beat.
- busy = (state==GROUP) | p_valid | CBB_valid.

Decomposition:
- Package imu_pkg holds:
  - mode encodings MODE_MUL=0, MODE_ACC=1;
  - FSM state enum {IDLE, GROUP};
  - default LANES/DW/ACC_W constants;
  - a lane-slice helper function.
- One sub-module imu_lane_mul: a single-lane masked multiply and ACC_W truncation, instantiated LANES times in a generate loop. The FSM, counter and handshake stay in the top module.

Test Plan:
- Per-beat multiply: mode=0, value=5, row lanes {0,1,2,3}, mask=4'hF, CBB_ready=1 → data lanes {0,5,10,15}, CBB_valid one cycle high, 2 edges after accept.
- Group of 3: mode=1, len=3, row lanes {1,2,3,4}, values 1,2,3 on consecutive cycles → single output with lanes {6,12,18,24}. No CBB_valid on the first two beats; acc is 0 afterwards (verified by a follow-up mode=0 beat value=1 giving {1,2,3,4}).
- Backpressure: output pending with CBB_ready=0 for 3 cycles → in_ready=0, data/CBB_valid stable. CBB_ready=1 → consumed, and the next result appears on the following edge with no beat lost.
- Wrap and mask: value=32'hFFFF_FFFF, row lane0=2, mask=4'b0001 → lane0=32'hFFFF_FFFE, lanes 1–3 = 0. Two-beat group of the same beat → lane0=32'hFFFF_FFFC.
- Reset mid-group: mode=1, len=4, 2 beats accepted, then rst pulse → CBB_valid=0, busy=0, FSM=IDLE. A new mode=0 beat value=5 row lanes {0,1,2,3} gives {0,5,10,15} with no residue from the discarded group.
- len=0 and mode latch: mode=1, len=0, value=7, row lane0=3 → immediate output lane0=21. Then open a len=2 group and toggle mode/len mid-group → the group still closes after exactly 2 beats.
